// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the two-port data-memory arbiter.
//
//   rd_tag_t : which requester owns the read whose data returns next cycle.
//   owner_t  : last port granted (used by the fair alternating policy).
//   STARVE_W : width of the port-1 starvation counter.
//
//   Optional build macro: DMEM_ARB_RR_EN (selects the alternating policy).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_P0,
    TAG_P1
  } rd_tag_t;

  typedef enum logic {
    OWN_P0,
    OWN_P1
  } owner_t;

  localparam int unsigned STARVE_W = 4;

  // Encode a read tag from a port grant and its write flag.
  function automatic rd_tag_t read_tag(input logic gnt0, input logic we0,
                                       input logic gnt1, input logic we1);
    rd_tag_t tag;
    tag = TAG_NONE;
    if (gnt0 && !we0) begin
      tag = TAG_P0;
    end else if (gnt1 && !we1) begin
      tag = TAG_P1;
    end
    return tag;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// -----------------------------------------------------------------------------
// dmem_arb_grant
//   Pure combinational grant logic for the data-memory arbiter.
//
//   Ports:
//     reset_n    in   1          synchronous active-low reset; forces no grant
//     req0       in   1          port-0 request
//     req1       in   1          port-1 request
//     starve_cnt in   STARVE_W   port-1 denied-cycle count (priority policy)
//     last_owner in   owner_t    last granted port (DMEM_ARB_RR_EN build)
//     gnt        out  2          one-hot grant, bit 0 = port 0, bit 1 = port 1
//
//   Build macro DMEM_ARB_RR_EN: when defined, conflicts alternate between the
//   two ports; otherwise port 0 has priority unless port 1 has been denied
//   MAX_WAIT consecutive cycles.
// -----------------------------------------------------------------------------
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                reset_n,
  input  logic                req0,
  input  logic                req1,
`ifdef DMEM_ARB_RR_EN
  input  owner_t              last_owner,
`else
  input  logic [STARVE_W-1:0] starve_cnt,
`endif
  output logic [1:0]          gnt
);

  logic p1_wins_conflict;

`ifdef DMEM_ARB_RR_EN
  // Fair alternation: whoever did not go last wins a tie.
  assign p1_wins_conflict = (last_owner == OWN_P0);
`else
  // Port 1 overrides the CPU only once its wait bound is reached.
  assign p1_wins_conflict = (starve_cnt == STARVE_W'(MAX_WAIT));
`endif

  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      if (req0 && req1) begin
        gnt = p1_wins_conflict ? 2'b10 : 2'b01;
      end else if (req0) begin
        gnt = 2'b01;
      end else if (req1) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data-memory port between the CPU load/store unit (port 0) and
//   a DMA / boot-loader master (port 1). Valid/grant handshake per port, one
//   transfer per cycle, reads tagged so the 1-cycle return data is steered
//   back to the requester that issued it.
//
//   Ports:
//     clk, reset_n                 clock, synchronous active-low reset
//     i_req0/i_we0/i_addr0/        port-0 request, write flag, byte address,
//       i_wdata0/i_be0             lane-aligned write data, byte enables
//     o_gnt0                       port-0 grant (transfer when req & gnt)
//     o_rvalid0/o_rdata0           port-0 read return (data is 0 when idle)
//     i_req1 ... o_rdata1          identical set for port 1
//     dmem_addr/dmem_wdata/dmem_be memory command (all 0 when nothing granted)
//     dmem_wren/dmem_rden          memory write / read strobes
//     dmem_rdata                   memory read data, valid 1 cycle after rden
//
//   Build macro DMEM_ARB_RR_EN: alternating fair policy instead of the default
//   port-0 priority with bounded port-1 starvation (MAX_WAIT).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                i_req0,
  input  logic                i_we0,
  input  logic [ADDR_W-1:0]   i_addr0,
  input  logic [DATA_W-1:0]   i_wdata0,
  input  logic [DATA_W/8-1:0] i_be0,
  output logic                o_gnt0,
  output logic                o_rvalid0,
  output logic [DATA_W-1:0]   o_rdata0,

  input  logic                i_req1,
  input  logic                i_we1,
  input  logic [ADDR_W-1:0]   i_addr1,
  input  logic [DATA_W-1:0]   i_wdata1,
  input  logic [DATA_W/8-1:0] i_be1,
  output logic                o_gnt1,
  output logic                o_rvalid1,
  output logic [DATA_W-1:0]   o_rdata1,

  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic                dmem_wren,
  output logic                dmem_rden,
  input  logic [DATA_W-1:0]   dmem_rdata
);

  logic [1:0] gnt;
  rd_tag_t    rd_tag_q;
  rd_tag_t    rd_tag_d;

`ifdef DMEM_ARB_RR_EN
  owner_t     last_owner_q;
`else
  logic [STARVE_W-1:0] starve_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  dmem_arb_grant #(
    .MAX_WAIT   (MAX_WAIT)
  ) u_grant (
    .reset_n    (reset_n),
    .req0       (i_req0),
    .req1       (i_req1),
`ifdef DMEM_ARB_RR_EN
    .last_owner (last_owner_q),
`else
    .starve_cnt (starve_cnt_q),
`endif
    .gnt        (gnt)
  );

  assign o_gnt0 = gnt[0];
  assign o_gnt1 = gnt[1];

  // ---------------------------------------------------------------------------
  // Memory command mux
  // ---------------------------------------------------------------------------
  always_comb begin
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    dmem_wren  = 1'b0;
    dmem_rden  = 1'b0;
    unique case (gnt)
      2'b01: begin
        dmem_addr  = i_addr0;
        dmem_wdata = i_wdata0;
        dmem_be    = i_be0;
        dmem_wren  = i_we0;
        dmem_rden  = ~i_we0;
      end
      2'b10: begin
        dmem_addr  = i_addr1;
        dmem_wdata = i_wdata1;
        dmem_be    = i_be1;
        dmem_wren  = i_we1;
        dmem_rden  = ~i_we1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read tag: remembers who owns the data the memory returns next cycle.
  // Grants are already suppressed during reset, so a read in flight when
  // reset is sampled never produces a return.
  // ---------------------------------------------------------------------------
  assign rd_tag_d = read_tag(gnt[0], i_we0, gnt[1], i_we1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_tag_q <= TAG_NONE;
    end else begin
      rd_tag_q <= rd_tag_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // ---------------------------------------------------------------------------
  // Alternating policy state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_owner_q <= OWN_P1;
    end else if (gnt[0]) begin
      last_owner_q <= OWN_P0;
    end else if (gnt[1]) begin
      last_owner_q <= OWN_P1;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Starvation counter: consecutive cycles port 1 has been held off. Clears as
  // soon as port 1 is served or withdraws; saturates at the bound so the
  // grant logic sees an exact match.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else if (!i_req1 || gnt[1]) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q != STARVE_W'(MAX_WAIT)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Return demux
  // ---------------------------------------------------------------------------
  assign o_rvalid0 = (rd_tag_q == TAG_P0);
  assign o_rvalid1 = (rd_tag_q == TAG_P1);
  assign o_rdata0  = o_rvalid0 ? dmem_rdata : '0;
  assign o_rdata1  = o_rvalid1 ? dmem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req0, i_we0, i_req1, i_we1;
  logic [31:0] i_addr0, i_wdata0, i_addr1, i_wdata1;
  logic [3:0]  i_be0, i_be1;
  logic        o_gnt0, o_rvalid0, o_gnt1, o_rvalid1;
  logic [31:0] o_rdata0, o_rdata1;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_wren, dmem_rden;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req0     (i_req0),
    .i_we0      (i_we0),
    .i_addr0    (i_addr0),
    .i_wdata0   (i_wdata0),
    .i_be0      (i_be0),
    .o_gnt0     (o_gnt0),
    .o_rvalid0  (o_rvalid0),
    .o_rdata0   (o_rdata0),
    .i_req1     (i_req1),
    .i_we1      (i_we1),
    .i_addr1    (i_addr1),
    .i_wdata1   (i_wdata1),
    .i_be1      (i_be1),
    .o_gnt1     (o_gnt1),
    .o_rvalid1  (o_rvalid1),
    .o_rdata1   (o_rdata1),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_wren  (dmem_wren),
    .dmem_rden  (dmem_rden),
    .dmem_rdata (dmem_rdata)
  );

  // Behavioural memory macro, 64 words, 1-cycle read latency.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (dmem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_be[b]) mem[dmem_addr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
    if (dmem_rden) dmem_rdata <= mem[dmem_addr[7:2]];
  end

  // Reference memory and read-return scoreboard.
  logic [31:0] ref_mem [64];
  typedef struct {
    bit          port;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check grant and memory command mid-cycle, check the read
  // return against the scoreboard, record new expectations, advance a clock.
  task automatic cyc(input bit eg0, input bit eg1, input bit drop_rst = 1'b0);
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    bit          ewr, erd, rv0, rv1;
    logic [31:0] rd0, rd1;
    sb_t         e;
    @(negedge clk);
    chk("gnt0", {31'd0, o_gnt0}, {31'd0, eg0});
    chk("gnt1", {31'd0, o_gnt1}, {31'd0, eg1});
    ea = '0; ew = '0; eb = '0; ewr = 1'b0; erd = 1'b0;
    if (eg0) begin
      ea = i_addr0; ew = i_wdata0; eb = i_be0; ewr = i_we0; erd = !i_we0;
    end else if (eg1) begin
      ea = i_addr1; ew = i_wdata1; eb = i_be1; ewr = i_we1; erd = !i_we1;
    end
    chk("dmem_addr", dmem_addr, ea);
    chk("dmem_wdata", dmem_wdata, ew);
    chk("dmem_be", {28'd0, dmem_be}, {28'd0, eb});
    chk("dmem_wren", {31'd0, dmem_wren}, {31'd0, ewr});
    chk("dmem_rden", {31'd0, dmem_rden}, {31'd0, erd});
    rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) begin rv1 = 1'b1; rd1 = e.data; end
      else        begin rv0 = 1'b1; rd0 = e.data; end
    end
    chk("rvalid0", {31'd0, o_rvalid0}, {31'd0, rv0});
    chk("rvalid1", {31'd0, o_rvalid1}, {31'd0, rv1});
    chk("rdata0", o_rdata0, rd0);
    chk("rdata1", o_rdata1, rd1);
    if (erd) begin
      e.port = eg1;
      e.data = ref_mem[ea[7:2]];
      sb.push_back(e);
    end
    if (ewr) begin
      for (int b = 0; b < 4; b++) begin
        if (eb[b]) ref_mem[ea[7:2]][8*b +: 8] = ew[8*b +: 8];
      end
    end
    if (drop_rst) reset_n = 1'b0;
    @(posedge clk);
    if (!reset_n) sb.delete();
    #1;
  endtask

  initial begin
    bit p1;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h5A5A_0000 ^ (32'h0101_0101 * i);
      ref_mem[i] = 32'h5A5A_0000 ^ (32'h0101_0101 * i);
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    dmem_rdata = '0;

    // Reset with both ports requesting: no grants, no strobes, no returns.
    reset_n = 1'b0;
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h0; i_wdata0 = '0; i_be0 = 4'hF;
    i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 32'h4; i_wdata1 = '0; i_be1 = 4'hF;
    repeat (3) cyc(1'b0, 1'b0);
    reset_n = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0;
    cyc(1'b0, 1'b0);

    // Single CPU read.
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h10;
    cyc(1'b1, 1'b0);
    i_req0 = 1'b0;
    cyc(1'b0, 1'b0);

    // Port-1 byte write, then port-0 word read of the same word.
    i_req1 = 1'b1; i_we1 = 1'b1; i_addr1 = 32'h23; i_be1 = 4'b1000; i_wdata1 = 32'hAB00_0000;
    cyc(1'b0, 1'b1);
    i_req1 = 1'b0;
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h20; i_be0 = 4'hF;
    cyc(1'b1, 1'b0);
    i_req0 = 1'b0;
    cyc(1'b0, 1'b0);

    // Write then read same address in consecutive cycles, back-to-back reads.
    i_req0 = 1'b1; i_we0 = 1'b1; i_addr0 = 32'h30; i_be0 = 4'b0011; i_wdata0 = 32'h1234_5678;
    cyc(1'b1, 1'b0);
    i_req0 = 1'b0;
    i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 32'h30; i_be1 = 4'hF;
    cyc(1'b0, 1'b1);
    i_req1 = 1'b0;
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h10; i_be0 = 4'hF;
    cyc(1'b1, 1'b0);
    i_req0 = 1'b0;
    cyc(1'b0, 1'b0);

    // Continuous contention from reset, interleaved reads of 0x0 and 0x4.
    reset_n = 1'b0;
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h0;
    i_req1 = 1'b1; i_we1 = 1'b0; i_addr1 = 32'h4;
    repeat (2) cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
`ifdef DMEM_ARB_RR_EN
      p1 = (i % 2) == 1;
`else
      p1 = (i % (MAX_WAIT + 1)) == MAX_WAIT;
`endif
      cyc(!p1, p1);
    end

`ifndef DMEM_ARB_RR_EN
    // Port 1 withdrawing clears its wait count; the full bound applies again.
    i_req1 = 1'b0;
    cyc(1'b1, 1'b0);
    i_req1 = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
`endif
    i_req0 = 1'b0; i_req1 = 1'b0;
    cyc(1'b0, 1'b0);

    // Reset sampled at the edge ending a granted read: no return afterwards.
    i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h10;
    cyc(1'b1, 1'b0, 1'b1);
    i_req0 = 1'b0;
    cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
